// File: rtl/vga_scanout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_scanout                                                   |
// | Purpose  : VGA raster generator with scaled framebuffer scan-out window. |
// |            Produces H/V timing, framebuffer read addresses and the       |
// |            DAC pin set (RGB, sync, blank, frame pulse), all aligned to   |
// |            the framebuffer read latency.                                 |
// | Ports    : CLOCK_50    - system clock                                    |
// |            reset       - synchronous reset, active low                   |
// |            pix_ce      - pixel clock enable, raster advances when 1      |
// |            border_rgb  - colour of active pixels outside the window      |
// |            fb_adr      - framebuffer read address                        |
// |            fb_q        - framebuffer read data {R,G,B}                   |
// |            VGA_R/G/B   - pixel colour                                    |
// |            VGA_HS/VS   - sync outputs, polarity set by HS_POL/VS_POL     |
// |            VGA_BLANK_N - 1 during active video                           |
// |            VGA_SYNC_N  - sync-on-green, tied 0                           |
// |            frame_start - one-clock pulse with the first pixel of a frame |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vga_scanout #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter bit HS_POL    = 1'b0,
   parameter bit VS_POL    = 1'b0,
   parameter int WIN_X0    = 40,
   parameter int WIN_Y0    = 48,
   parameter int WIN_W     = 560,
   parameter int WIN_H     = 384,
   parameter int SCALE     = 2,
   parameter int ADDR_W    = 16,
   parameter int RAM_LAT   = 1
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              pix_ce,
   input  logic [23:0]       border_rgb,
   output logic [ADDR_W-1:0] fb_adr,
   input  logic [23:0]       fb_q,
   output logic [7:0]        VGA_R,
   output logic [7:0]        VGA_G,
   output logic [7:0]        VGA_B,
   output logic              VGA_HS,
   output logic              VGA_VS,
   output logic              VGA_BLANK_N,
   output logic              VGA_SYNC_N,
   output logic              frame_start
);

   localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   // One spare count so that end-of-sync bounds equal to the total still fit.
   localparam int c_HW = $clog2(c_H_TOTAL + 1);
   localparam int c_VW = $clog2(c_V_TOTAL + 1);
   localparam int c_SW = (SCALE > 1) ? $clog2(SCALE) : 1;

   localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
   localparam logic [c_HW-1:0] c_H_VIS    = c_HW'(H_VISIBLE);
   localparam logic [c_HW-1:0] c_HS_BEG   = c_HW'(H_VISIBLE + H_FRONT);
   localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [c_HW-1:0] c_WX0      = c_HW'(WIN_X0);
   localparam logic [c_HW-1:0] c_WX1      = c_HW'(WIN_X0 + WIN_W);
   localparam logic [c_HW-1:0] c_WX_LAST  = c_HW'(WIN_X0 + WIN_W - 1);
   localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
   localparam logic [c_VW-1:0] c_V_VIS    = c_VW'(V_VISIBLE);
   localparam logic [c_VW-1:0] c_VS_BEG   = c_VW'(V_VISIBLE + V_FRONT);
   localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [c_VW-1:0] c_WY0      = c_VW'(WIN_Y0);
   localparam logic [c_VW-1:0] c_WY1      = c_VW'(WIN_Y0 + WIN_H);
   localparam logic [c_SW-1:0] c_S_LAST   = c_SW'(SCALE - 1);
   localparam logic [ADDR_W-1:0] c_ROW_STEP = ADDR_W'(WIN_W / SCALE);

   // ---------------- parameter sanity ----------------
   generate
      if (SCALE < 1) begin : g_err_scale
         $error("vga_scanout: SCALE must be at least 1");
      end
      if ((WIN_X0 < 0) || (WIN_Y0 < 0) || (WIN_X0 + WIN_W > H_VISIBLE) ||
          (WIN_Y0 + WIN_H > V_VISIBLE)) begin : g_err_win
         $error("vga_scanout: window exceeds the visible area");
      end
      if ((SCALE >= 1) && (((WIN_W % SCALE) != 0) || ((WIN_H % SCALE) != 0))) begin : g_err_mult
         $error("vga_scanout: WIN_W and WIN_H must be multiples of SCALE");
      end
      if ((SCALE >= 1) &&
          (64'(WIN_W / SCALE) * 64'(WIN_H / SCALE) > (64'd1 << ADDR_W))) begin : g_err_adr
         $error("vga_scanout: window does not fit the framebuffer address space");
      end
   endgenerate

   // ---------------- S0: raster counters ----------------
   logic [c_HW-1:0] r_h;
   logic [c_VW-1:0] r_v;

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         r_h <= '0;
         r_v <= '0;
      end else if (pix_ce) begin
         if (r_h == c_H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == c_V_LAST) ? '0 : r_v + 1'b1;
         end else begin
            r_h <= r_h + 1'b1;
         end
      end
   end

   logic w_active, w_win, w_win_last_x, w_hs, w_vs, w_frame, w_frame_end;

   assign w_active     = (r_h < c_H_VIS) && (r_v < c_V_VIS);
   assign w_win        = (r_h >= c_WX0) && (r_h < c_WX1) && (r_v >= c_WY0) && (r_v < c_WY1);
   assign w_win_last_x = w_win && (r_h == c_WX_LAST);
   assign w_hs         = (r_h >= c_HS_BEG) && (r_h < c_HS_END);
   assign w_vs         = (r_v >= c_VS_BEG) && (r_v < c_VS_END);
   assign w_frame      = (r_h == '0) && (r_v == '0);
   assign w_frame_end  = (r_h == c_H_LAST) && (r_v == c_V_LAST);

   // ---------------- S1: framebuffer address ----------------
   // Column index advances once every SCALE window pixels and each row base is
   // reused for SCALE lines, which replicates pixels without a divider.
   logic [ADDR_W-1:0] r_row_base;
   logic [ADDR_W-1:0] r_col;
   logic [c_SW-1:0]   r_xsub;
   logic [c_SW-1:0]   r_ysub;

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         fb_adr     <= '0;
         r_row_base <= '0;
         r_col      <= '0;
         r_xsub     <= '0;
         r_ysub     <= '0;
      end else if (pix_ce) begin
         if (w_win) begin
            fb_adr <= r_row_base + r_col;
            if (w_win_last_x) begin
               r_col  <= '0;
               r_xsub <= '0;
               if (r_ysub == c_S_LAST) begin
                  r_ysub     <= '0;
                  r_row_base <= r_row_base + c_ROW_STEP;
               end else begin
                  r_ysub <= r_ysub + 1'b1;
               end
            end else if (r_xsub == c_S_LAST) begin
               r_xsub <= '0;
               r_col  <= r_col + 1'b1;
            end else begin
               r_xsub <= r_xsub + 1'b1;
            end
         end
         // Last raster position of the frame is never inside the window, so
         // this rewind cannot collide with a row-base step.
         if (w_frame_end) begin
            r_row_base <= '0;
            r_ysub     <= '0;
         end
      end
   end

   // ---------------- control pipe + pin register ----------------
   // Stage 0 is loaded alongside fb_adr; stage RAM_LAT lines up with fb_q.
   logic [RAM_LAT:0] r_p_win, r_p_act, r_p_hs, r_p_vs, r_p_frm;

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         r_p_win     <= '0;
         r_p_act     <= '0;
         r_p_hs      <= '0;
         r_p_vs      <= '0;
         r_p_frm     <= '0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
         VGA_HS      <= ~HS_POL;
         VGA_VS      <= ~VS_POL;
         VGA_BLANK_N <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         // Qualified by pix_ce so the pulse lasts one clock even though the
         // pins themselves hold between enables.
         frame_start <= pix_ce & r_p_frm[RAM_LAT];
         if (pix_ce) begin
            r_p_win[0] <= w_win;
            r_p_act[0] <= w_active;
            r_p_hs[0]  <= w_hs;
            r_p_vs[0]  <= w_vs;
            r_p_frm[0] <= w_frame;
            for (int i = 1; i <= RAM_LAT; i++) begin
               r_p_win[i] <= r_p_win[i-1];
               r_p_act[i] <= r_p_act[i-1];
               r_p_hs[i]  <= r_p_hs[i-1];
               r_p_vs[i]  <= r_p_vs[i-1];
               r_p_frm[i] <= r_p_frm[i-1];
            end
            if (r_p_win[RAM_LAT]) begin
               {VGA_R, VGA_G, VGA_B} <= fb_q;
            end else if (r_p_act[RAM_LAT]) begin
               {VGA_R, VGA_G, VGA_B} <= border_rgb;
            end else begin
               {VGA_R, VGA_G, VGA_B} <= 24'h000000;
            end
            VGA_HS      <= r_p_hs[RAM_LAT] ? HS_POL : ~HS_POL;
            VGA_VS      <= r_p_vs[RAM_LAT] ? VS_POL : ~VS_POL;
            VGA_BLANK_N <= r_p_act[RAM_LAT];
         end
      end
   end

   assign VGA_SYNC_N = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vga_scanout                                                |
// | Purpose  : Self-checking bench for vga_scanout. Two reduced-size rasters |
// |            (SCALE=2/RAM_LAT=1 with a border, and SCALE=1/RAM_LAT=2 with  |
// |            positive syncs and a full-screen window) are compared every   |
// |            clock against a raster model built from plain arithmetic.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_vga_scanout;

   typedef struct {
      int hv, hf, hs, hb, vv, vf, vs, vb;
      int wx, wy, ww, wh, sc, lat;
      bit hpol, vpol;
   } cfg_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_ce;
   logic [23:0] border_rgb;

   logic [7:0]  adr_a, adr_b;
   logic [23:0] q_a = '0, q_b0 = '0, q_b1 = '0;
   logic [7:0]  ra, ga, ba, rb, gb, bb;
   logic        hs_a, vs_a, bl_a, sy_a, fs_a;
   logic        hs_b, vs_b, bl_b, sy_b, fs_b;

   logic [23:0] mem [0:1][0:255];

   cfg_t cfg_a, cfg_b;
   int   n_cmp, n_err;
   int   c;              // pixel-enable edges since reset release
   int   exp_adr [0:1];
   bit   fr_edge;

   always #5 clk = ~clk;

   vga_scanout #(
      .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
      .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .HS_POL(1'b0), .VS_POL(1'b0),
      .WIN_X0(4), .WIN_Y0(2), .WIN_W(12), .WIN_H(8),
      .SCALE(2), .ADDR_W(8), .RAM_LAT(1)
   ) u_dut_a (
      .CLOCK_50(clk), .reset(reset), .pix_ce(pix_ce), .border_rgb(border_rgb),
      .fb_adr(adr_a), .fb_q(q_a),
      .VGA_R(ra), .VGA_G(ga), .VGA_B(ba), .VGA_HS(hs_a), .VGA_VS(vs_a),
      .VGA_BLANK_N(bl_a), .VGA_SYNC_N(sy_a), .frame_start(fs_a)
   );

   vga_scanout #(
      .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
      .HS_POL(1'b1), .VS_POL(1'b1),
      .WIN_X0(0), .WIN_Y0(0), .WIN_W(16), .WIN_H(10),
      .SCALE(1), .ADDR_W(8), .RAM_LAT(2)
   ) u_dut_b (
      .CLOCK_50(clk), .reset(reset), .pix_ce(pix_ce), .border_rgb(border_rgb),
      .fb_adr(adr_b), .fb_q(q_b1),
      .VGA_R(rb), .VGA_G(gb), .VGA_B(bb), .VGA_HS(hs_b), .VGA_VS(vs_b),
      .VGA_BLANK_N(bl_b), .VGA_SYNC_N(sy_b), .frame_start(fs_b)
   );

   // Framebuffers: random contents, read latency counted in pixel enables.
   always @(posedge clk) begin
      if (pix_ce) begin
         q_a  <= mem[0][adr_a];
         q_b0 <= mem[1][adr_b];
         q_b1 <= q_b0;
      end
   end

   // ---------------- reference model ----------------
   function automatic int h_tot(input cfg_t k);
      return k.hv + k.hf + k.hs + k.hb;
   endfunction

   function automatic int frame_len(input cfg_t k);
      return h_tot(k) * (k.vv + k.vf + k.vs + k.vb);
   endfunction

   function automatic bit in_win(input cfg_t k, input int h, input int v);
      return (h >= k.wx) && (h < k.wx + k.ww) && (v >= k.wy) && (v < k.wy + k.wh);
   endfunction

   function automatic int win_adr(input cfg_t k, input int h, input int v);
      return ((v - k.wy) / k.sc) * (k.ww / k.sc) + (h - k.wx) / k.sc;
   endfunction

   // Pins show the pixel that entered the raster lat+2 enables earlier.
   function automatic logic [27:0] exp_pins(input cfg_t k, input int i);
      int q, h, v;
      logic act, hsa, vsa;
      logic [23:0] rgb;
      if (c < k.lat + 2) return {24'h000000, ~k.hpol, ~k.vpol, 2'b00};
      q   = (c - (k.lat + 2)) % frame_len(k);
      h   = q % h_tot(k);
      v   = q / h_tot(k);
      act = (h < k.hv) && (v < k.vv);
      hsa = (h >= k.hv + k.hf) && (h < k.hv + k.hf + k.hs);
      vsa = (v >= k.vv + k.vf) && (v < k.vv + k.vf + k.vs);
      if (in_win(k, h, v))  rgb = mem[i][win_adr(k, h, v)];
      else if (act)         rgb = border_rgb;
      else                  rgb = 24'h000000;
      return {rgb, hsa ? k.hpol : ~k.hpol, vsa ? k.vpol : ~k.vpol, act, 1'b0};
   endfunction

   function automatic logic exp_frame(input cfg_t k);
      return fr_edge && (c >= k.lat + 2) && (((c - (k.lat + 2)) % frame_len(k)) == 0);
   endfunction

   // The address register follows the most recent window pixel.
   task automatic note_adr(input cfg_t k, input int i);
      int q, h, v;
      q = c % frame_len(k);
      h = q % h_tot(k);
      v = q / h_tot(k);
      if (in_win(k, h, v)) exp_adr[i] = win_adr(k, h, v);
   endtask

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   // Drive one clock of stimulus (at a negedge), advance the model across the
   // coming posedge, then compare at the following negedge.
   task automatic step(input logic rn, input logic ce);
      reset  = rn;
      pix_ce = ce;
      if (!rn) begin
         c          = 0;
         exp_adr[0] = 0;
         exp_adr[1] = 0;
         fr_edge    = 1'b0;
      end else if (ce) begin
         note_adr(cfg_a, 0);
         note_adr(cfg_b, 1);
         c++;
         fr_edge = 1'b1;
      end else begin
         fr_edge = 1'b0;
      end
      @(negedge clk);
      check_eq("pins_a",  32'({ra, ga, ba, hs_a, vs_a, bl_a, sy_a}), 32'(exp_pins(cfg_a, 0)));
      check_eq("adr_a",   32'(adr_a), 32'(exp_adr[0]));
      check_eq("frame_a", 32'(fs_a),  32'(exp_frame(cfg_a)));
      check_eq("pins_b",  32'({rb, gb, bb, hs_b, vs_b, bl_b, sy_b}), 32'(exp_pins(cfg_b, 1)));
      check_eq("adr_b",   32'(adr_b), 32'(exp_adr[1]));
      check_eq("frame_b", 32'(fs_b),  32'(exp_frame(cfg_b)));
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      c       = 0;
      fr_edge = 1'b0;
      exp_adr[0] = 0;
      exp_adr[1] = 0;
      cfg_a = '{hv: 20, hf: 3, hs: 4, hb: 5, vv: 12, vf: 2, vs: 2, vb: 3,
                wx: 4, wy: 2, ww: 12, wh: 8, sc: 2, lat: 1, hpol: 1'b0, vpol: 1'b0};
      cfg_b = '{hv: 16, hf: 2, hs: 3, hb: 3, vv: 10, vf: 1, vs: 2, vb: 2,
                wx: 0, wy: 0, ww: 16, wh: 10, sc: 1, lat: 2, hpol: 1'b1, vpol: 1'b1};
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 256; j++)
            mem[i][j] = 24'($urandom);

      reset      = 1'b0;
      pix_ce     = 1'b0;
      border_rgb = 24'($urandom);
      @(negedge clk);

      // Reset state, with pix_ce toggling to show reset dominates.
      for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)));
      // Enable on every second clock.
      for (int i = 0; i < 1400; i++) step(1'b1, 1'(i % 2));
      // Back-to-back enables.
      for (int i = 0; i < 800; i++) step(1'b1, 1'b1);
      // Random enables with a 50-clock stall mid-stream.
      for (int i = 0; i < 1500; i++)
         step(1'b1, ((i >= 700) && (i < 750)) ? 1'b0 : ($urandom_range(0, 99) < 70));
      // Mid-frame reset, green border afterwards.
      border_rgb = 24'h00FF00;
      for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 2000; i++) step(1'b1, ($urandom_range(0, 99) < 60));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
